lfsr_word_gen: RTL and testbench
================================

Name: lfsr_word_gen

Overview:
- 16-bit maximal-length Fibonacci LFSR that produces pseudo-random words for the downstream pattern-detector FSM, which consumes the full word plus the serial feedback bit.
- Adds seed loading, a zero-seed guard and a valid/ready word handshake, so the detector never misses or double-samples a word.
- Issues a period-complete tick after 65535 steps.
- Optional one-shot mode halts generation after one full period.

Parameters:
- DEFAULT_SEED, 16'hACE1, seed used after reset and whenever a zero seed is loaded.
- ONE_SHOT, 0, when 1 the generator stops in DONE after one full period.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  permits stepping
- load_seed  in  1  synchronous seed-load strobe
- seed  in  16  seed value, sampled when load_seed=1
- word_ready  in  1  downstream accepts lfsr_reg this cycle
- lfsr_reg  out  16  current LFSR word
- word_valid  out  1  lfsr_reg holds an unconsumed new word
- lfsr_out  out  1  feedback bit produced by the most recent step
- max_tick_reg  out  1  one-cycle pulse when the step count completes 65535 steps
- seed_fault  out  1  one-cycle pulse when a zero seed is loaded
- stall_cnt  out  16  stall statistics (optional feature)

Behaviour:
- Clock and reset: clk, with reset asynchronous and active-high. All state is registered.
- Reset values:
  - lfsr_reg=DEFAULT_SEED
  - word_valid=0, lfsr_out=0, max_tick_reg=0, seed_fault=0
  - step counter (16-bit)=0, stall_cnt=0
  - state=IDLE
- Polynomial: x^16+x^15+x^13+x^4+1.
  - fb = lfsr_reg[15]^lfsr_reg[14]^lfsr_reg[12]^lfsr_reg[3].
  - Step: lfsr_reg <= {lfsr_reg[14:0], fb}; lfsr_out <= fb.
- Step condition: step = en && (state != DONE) && (!word_valid || word_ready) && !load_seed.
- Handshake:
  - A step sets word_valid=1 in the next cycle. Latency from the step cycle to the new word being visible is 1 clk.
  - If word_valid && word_ready && !step, then word_valid <= 0.
  - While word_valid && !word_ready, lfsr_reg and lfsr_out hold stable.
- States:
  - IDLE -> RUN on the first step.
  - RUN stays in RUN. When the step counter wraps and ONE_SHOT=1, RUN -> DONE.
  - DONE: no stepping. word_valid still clears on word_ready.
  - Any state -> IDLE on load_seed.
- Period tick:
  - The step counter increments on each step.
  - The step that takes the counter from 65534 to 65535 asserts max_tick_reg for exactly 1 cycle and clears the counter to 0.
  - At that point lfsr_reg equals the seed it started from.
- Seed load (priority over stepping in the same cycle):
  - lfsr_reg <= (seed==0 ? DEFAULT_SEED : seed).
  - word_valid <= 0, step counter <= 0, lfsr_out <= 0.
  - seed_fault pulses 1 cycle if seed==0.
- lfsr_reg never holds 0: the only entry points are reset and seed load, and both are guarded.
- Reset mid-handshake: the pending word is discarded and word_valid drops immediately (asynchronous).
- en=0: state and lfsr_reg are frozen. A pending word may still be accepted.

Optional Feature:
- LFSR_STALL_CNT_EN defined:
  - stall_cnt counts cycles with word_valid && !word_ready, saturating at 16'hFFFF.
  - Cleared by reset and by load_seed.
- LFSR_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter logic is present.

Decomposition:
- Shared package holds:
  - LFSR_W=16
  - tap positions (15,14,12,3)
  - PERIOD=16'hFFFF
  - state typedef {IDLE, RUN, DONE}
- One natural sub-module: lfsr_step, a combinational next-state/feedback function (word in; next word and fb out). It is reusable by the detector's reference model in the bench.

Test Plan:
- Reset value: reset released, en=1, word_ready=1 -> first word 16'h59C3 with lfsr_out=1, one cycle after the first step.
- Seed sequence: load seed=16'h0001, en=1, ready=1 -> words 0x0002, 0x0004, 0x0008, 0x0011 on consecutive steps.
- Backpressure: word_ready=0 for 5 cycles while word_valid=1 -> lfsr_reg stable; stall_cnt=5 with LFSR_STALL_CNT_EN; no step occurs until ready=1.
- Zero seed: load seed=0 -> lfsr_reg=16'hACE1, seed_fault high exactly 1 cycle, word_valid=0.
- Full period: from seed 0x0001 with continuous ready, max_tick_reg pulses once on step 65535 and lfsr_reg=0x0001. With ONE_SHOT=1, no further steps and state=DONE until load_seed.
- Collision: load_seed and a step-eligible cycle coincide -> load wins, counter=0; an asynchronous reset mid-run returns all outputs to their reset values.

Source files
------------

// File: rtl/lfsr_word_gen_pkg.sv
// Shared types and constants for the 16-bit LFSR word generator and its step function.
package lfsr_word_gen_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps for x^16 + x^15 + x^13 + x^4 + 1 (zero-based bit positions).
    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    // A maximal-length 16-bit sequence repeats after 2^16 - 1 steps.
    localparam logic [LFSR_W-1:0] PERIOD = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lfsr_state_t;

    typedef struct packed {
        lfsr_state_t         state;
        logic [LFSR_W-1:0]   step_cnt;
    } lfsr_dbg_t;

endpackage

// File: rtl/lfsr_word_gen_step.sv
// Pure combinational Fibonacci step: next word and the feedback bit shifted in.
module lfsr_step
    import lfsr_word_gen_pkg::*;
(
    input  logic [LFSR_W-1:0] word,
    output logic [LFSR_W-1:0] next_word,
    output logic              fb
);

    assign fb        = word[TAP_A] ^ word[TAP_B] ^ word[TAP_C] ^ word[TAP_D];
    assign next_word = {word[LFSR_W-2:0], fb};

endmodule

// File: rtl/lfsr_word_gen.sv
// LFSR word generator with seed load, zero-seed guard, valid/ready output and period tick.
// Optional stall statistics are built when LFSR_STALL_CNT_EN is defined.
module lfsr_word_gen
    import lfsr_word_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1,
    parameter bit                ONE_SHOT     = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load_seed,
    input  logic [LFSR_W-1:0] seed,
    input  logic              word_ready,
    output logic [LFSR_W-1:0] lfsr_reg,
    output logic              word_valid,
    output logic              lfsr_out,
    output logic              max_tick_reg,
    output logic              seed_fault,
    output logic [LFSR_W-1:0] stall_cnt,
    output lfsr_dbg_t         dbg
);

    // Handshake: a word is transferred on any rising clk edge where word_valid
    // and word_ready are both high. Once word_valid rises, lfsr_reg and lfsr_out
    // stay unchanged until that transfer happens (or a seed load or reset
    // discards the word). A step in the transfer cycle presents the next word
    // immediately, so a ready consumer sees a fresh word on every cycle.

    lfsr_state_t       state_q;
    lfsr_state_t       state_d;
    logic [LFSR_W-1:0] step_cnt;
    logic [LFSR_W-1:0] next_word;
    logic [LFSR_W-1:0] load_value;
    logic              fb;
    logic              step;
    logic              wrap;
    logic              seed_is_zero;

    lfsr_step u_step (
        .word      (lfsr_reg),
        .next_word (next_word),
        .fb        (fb)
    );

    assign seed_is_zero = (seed == '0);
    assign load_value   = seed_is_zero ? DEFAULT_SEED : seed;

    assign step = en && (state_q != DONE) && (!word_valid || word_ready) && !load_seed;

    // The 65535th step returns the register to its starting seed.
    assign wrap = step && (step_cnt == PERIOD - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_seed) begin
            state_d = IDLE;
        end else if (step) begin
            if (wrap && ONE_SHOT) begin
                state_d = DONE;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg     <= DEFAULT_SEED;
            word_valid   <= 1'b0;
            lfsr_out     <= 1'b0;
            max_tick_reg <= 1'b0;
            seed_fault   <= 1'b0;
            step_cnt     <= '0;
        end else begin
            max_tick_reg <= 1'b0;
            seed_fault   <= 1'b0;
            if (load_seed) begin
                lfsr_reg   <= load_value;
                word_valid <= 1'b0;
                lfsr_out   <= 1'b0;
                step_cnt   <= '0;
                seed_fault <= seed_is_zero;
            end else if (step) begin
                lfsr_reg   <= next_word;
                lfsr_out   <= fb;
                word_valid <= 1'b1;
                if (wrap) begin
                    step_cnt     <= '0;
                    max_tick_reg <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 16'd1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

`ifdef LFSR_STALL_CNT_EN
    logic [LFSR_W-1:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (load_seed) begin
            stall_q <= '0;
        end else if (word_valid && !word_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign dbg = '{state: state_q, step_cnt: step_cnt};

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Bench for lfsr_word_gen: a free-running and a one-shot instance share one directed stimulus.
module tb_lfsr_word_gen;
    import lfsr_word_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load_seed = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        word_ready = 1'b0;

    logic [15:0] lfsr_reg0, lfsr_reg1, stall_cnt0, stall_cnt1;
    logic        word_valid0, word_valid1, lfsr_out0, lfsr_out1;
    logic        max_tick0, max_tick1, seed_fault0, seed_fault1;
    lfsr_dbg_t   dbg0, dbg1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_word_gen #(.DEFAULT_SEED(16'hACE1), .ONE_SHOT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .load_seed(load_seed), .seed(seed),
        .word_ready(word_ready), .lfsr_reg(lfsr_reg0), .word_valid(word_valid0),
        .lfsr_out(lfsr_out0), .max_tick_reg(max_tick0), .seed_fault(seed_fault0),
        .stall_cnt(stall_cnt0), .dbg(dbg0)
    );

    lfsr_word_gen #(.DEFAULT_SEED(16'hACE1), .ONE_SHOT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .load_seed(load_seed), .seed(seed),
        .word_ready(word_ready), .lfsr_reg(lfsr_reg1), .word_valid(word_valid1),
        .lfsr_out(lfsr_out1), .max_tick_reg(max_tick1), .seed_fault(seed_fault1),
        .stall_cnt(stall_cnt1), .dbg(dbg1)
    );

    // Behavioural model: word history as plain shift arithmetic, steps counted since the last load.
    typedef struct {
        logic [15:0] word;
        logic        valid;
        logic        out;
        logic        tick;
        logic        fault;
        int          steps;
        bit          done;
        int          stall;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.word = 16'hACE1; m.valid = 0; m.out = 0; m.tick = 0; m.fault = 0;
        m.steps = 0; m.done = 0; m.stall = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, logic en_i, logic load_i, logic [15:0] seed_i,
                                      logic ready_i, bit one_shot);
        mdl_t n = m;
        logic fb;
        n.tick = 0;
        n.fault = 0;
        if (load_i) begin
            n = mdl_reset();
            n.word = (seed_i == 16'h0) ? 16'hACE1 : seed_i;
            n.fault = (seed_i == 16'h0);
            return n;
        end
        if (m.valid && !ready_i && m.stall < 65535) n.stall = m.stall + 1;
        if (en_i && !m.done && (!m.valid || ready_i)) begin
            fb = ^(m.word & 16'hD008);
            n.word = {m.word[14:0], fb};
            n.out = fb;
            n.valid = 1;
            n.steps = m.steps + 1;
            n.tick = (n.steps % 65535 == 0);
            if (one_shot && n.steps == 65535) n.done = 1;
        end else if (m.valid && ready_i) begin
            n.valid = 0;
        end
        return n;
    endfunction

    function automatic logic [63:0] exp_vec(mdl_t m);
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [15:0] stl;
        st  = m.done ? 2'(DONE) : ((m.steps > 0) ? 2'(RUN) : 2'(IDLE));
        cnt = 16'(m.steps % 65535);
`ifdef LFSR_STALL_CNT_EN
        stl = 16'(m.stall);
`else
        stl = 16'h0;
`endif
        return {10'b0, m.word, m.valid, m.out, m.tick, m.fault, stl, st, cnt};
    endfunction

    function automatic logic [63:0] act_vec(logic [15:0] w, logic v, logic o, logic t, logic f,
                                            logic [15:0] s, lfsr_dbg_t d);
        return {10'b0, w, v, o, t, f, s, 2'(d.state), d.step_cnt};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    mdl_t m0 = mdl_reset();
    mdl_t m1 = mdl_reset();

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end else begin
            m0 = mdl_next(m0, en, load_seed, seed, word_ready, 1'b0);
            m1 = mdl_next(m1, en, load_seed, seed, word_ready, 1'b1);
        end
    end

    // Fields: word, valid, lfsr_out, tick, seed_fault, stall_cnt, state, step count.
    always @(negedge clk) begin
        check("model_dut0", act_vec(lfsr_reg0, word_valid0, lfsr_out0, max_tick0, seed_fault0,
                                    stall_cnt0, dbg0), exp_vec(m0));
        check("model_dut1", act_vec(lfsr_reg1, word_valid1, lfsr_out1, max_tick1, seed_fault1,
                                    stall_cnt1, dbg1), exp_vec(m1));
    end

    task automatic next_cycle();
        @(negedge clk);
        #2;
    endtask

    int ticks;

    initial begin
        next_cycle();
        check("reset_word", 64'(lfsr_reg0), 64'h ACE1);
        check("reset_valid", 64'(word_valid0), 64'h0);
        check("reset_state", 64'(dbg0.state), 64'(IDLE));
        reset = 1'b0;
        en = 1'b1;
        word_ready = 1'b1;
        next_cycle();
        check("first_word", 64'(lfsr_reg0), 64'h59C3);
        check("first_out", 64'(lfsr_out0), 64'h1);
        check("first_valid", 64'(word_valid0), 64'h1);
        next_cycle();

        load_seed = 1'b1; seed = 16'h0001;
        next_cycle();
        check("load_word", 64'(lfsr_reg0), 64'h0001);
        check("load_valid", 64'(word_valid0), 64'h0);
        load_seed = 1'b0;
        next_cycle(); check("seq_0002", 64'(lfsr_reg0), 64'h0002);
        next_cycle(); check("seq_0004", 64'(lfsr_reg0), 64'h0004);
        next_cycle(); check("seq_0008", 64'(lfsr_reg0), 64'h0008);
        next_cycle(); check("seq_0011", 64'(lfsr_reg0), 64'h0011);

        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("stall_hold", 64'(lfsr_reg0), 64'h0011);
        end
`ifdef LFSR_STALL_CNT_EN
        check("stall_cnt5", 64'(stall_cnt0), 64'd5);
`else
        check("stall_tied", 64'(stall_cnt0), 64'd0);
`endif
        word_ready = 1'b1;
        next_cycle();
        check("after_stall", 64'(lfsr_reg0), 64'h0022);

        en = 1'b0; word_ready = 1'b0;
        next_cycle();
        check("en0_pending", 64'(word_valid0), 64'h1);
        word_ready = 1'b1;
        next_cycle();
        check("en0_accept", 64'(word_valid0), 64'h0);
        check("en0_frozen", 64'(lfsr_reg0), 64'h0022);

        load_seed = 1'b1; seed = 16'h0000;
        next_cycle();
        check("zero_seed_word", 64'(lfsr_reg0), 64'h ACE1);
        check("zero_seed_fault", 64'(seed_fault0), 64'h1);
        load_seed = 1'b0;
        next_cycle();
        check("zero_seed_pulse", 64'(seed_fault0), 64'h0);

        en = 1'b1;
        repeat (3) next_cycle();
        load_seed = 1'b1; seed = 16'h1234;
        next_cycle();
        check("collide_word", 64'(lfsr_reg0), 64'h1234);
        check("collide_cnt", 64'(dbg0.step_cnt), 64'h0);
        load_seed = 1'b0;
        repeat (3) next_cycle();

        reset = 1'b1;
        #1;
        check("async_valid", 64'(word_valid0), 64'h0);
        check("async_word", 64'(lfsr_reg0), 64'h ACE1);
        check("async_out", 64'(lfsr_out0), 64'h0);
        next_cycle();
        reset = 1'b0;

        load_seed = 1'b1; seed = 16'h0001;
        next_cycle();
        load_seed = 1'b0;
        ticks = 0;
        for (int i = 0; i < 65535; i++) begin
            next_cycle();
            if (max_tick0) ticks++;
        end
        check("period_ticks", 64'(ticks), 64'd1);
        check("period_tick_now", 64'(max_tick0), 64'h1);
        check("period_word", 64'(lfsr_reg0), 64'h0001);
        check("oneshot_done", 64'(dbg1.state), 64'(DONE));
        repeat (3) next_cycle();
        check("oneshot_hold", 64'(lfsr_reg1), 64'h0001);
        check("oneshot_drained", 64'(word_valid1), 64'h0);
        load_seed = 1'b1; seed = 16'h0001;
        next_cycle();
        check("oneshot_reload", 64'(dbg1.state), 64'(IDLE));
        load_seed = 1'b0;
        repeat (2) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
